pulse_stretcher: RTL

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher_pkg.sv | 10 +
 rtl/pulse_stretcher_if.sv | 20 ++
 rtl/pulse_counter.sv | 27 ++
 rtl/pulse_stretcher.sv | 109 ++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse-family blocks: FSM state encoding.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } pulse_state_e;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger/width inputs and stretched/busy/dropped status of a pulse stretcher.
interface pulse_stretcher_if #(
  parameter int WIDTH_BITS = 8
);
  logic                  pulse_in;
  logic [WIDTH_BITS-1:0] width;
  logic                  stretched;
  logic                  busy;
  logic                  dropped;

  modport master (
    output pulse_in, width,
    input  stretched, busy, dropped
  );

  modport slave (
    input  pulse_in, width,
    output stretched, busy, dropped
  );
endinterface

// File: rtl/pulse_counter.sv
// Loadable down-counter with a zero flag; decrement saturates at zero.
module pulse_counter #(
  parameter int WIDTH_BITS = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [WIDTH_BITS-1:0] load_value,
  input  logic                  dec,
  output logic                  zero
);

  logic [WIDTH_BITS-1:0] count_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH_BITS'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches each accepted trigger to a width-cycle pulse, then enforces a MIN_GAP low gap.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int WIDTH_BITS = 8,
  parameter int RETRIGGER  = 0,
  parameter int MIN_GAP    = 1
) (
  input  logic        clock,
  input  logic        resetn,
  pulse_stretcher_if.slave bus
);

  if ((MIN_GAP < 0) || (longint'(MIN_GAP) >= (longint'(1) << WIDTH_BITS))) begin : g_bad_gap
    $error("MIN_GAP does not fit in WIDTH_BITS");
  end

  localparam bit RETRIG_EN = (RETRIGGER != 0);
  localparam logic [WIDTH_BITS-1:0] GAP_LOAD =
      (MIN_GAP > 0) ? WIDTH_BITS'(MIN_GAP - 1) : '0;

  pulse_state_e          state_reg, state_next;
  logic                  stretched_reg, stretched_next;
  logic                  dropped_reg, dropped_next;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic [WIDTH_BITS-1:0] cnt_load_value;
  logic [WIDTH_BITS-1:0] pulse_len_m1;

  // width==0 behaves as a one-cycle pulse
  assign pulse_len_m1 = (bus.width == '0) ? '0 : bus.width - WIDTH_BITS'(1);

  pulse_counter #(
    .WIDTH_BITS (WIDTH_BITS)
  ) u_counter (
    .clock      (clock),
    .resetn     (resetn),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_next     = state_reg;
    stretched_next = 1'b0;
    dropped_next   = 1'b0;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cnt_load_value = pulse_len_m1;
    case (state_reg)
      IDLE: begin
        if (bus.pulse_in) begin
          state_next     = ACTIVE;
          cnt_load       = 1'b1;
          stretched_next = 1'b1;
        end
      end
      ACTIVE: begin
        // a reload takes priority over expiry so the output never glitches low
        if (bus.pulse_in && RETRIG_EN) begin
          cnt_load       = 1'b1;
          stretched_next = 1'b1;
        end else begin
          dropped_next = bus.pulse_in;
          if (cnt_zero) begin
            if (MIN_GAP > 0) begin
              state_next     = GAP;
              cnt_load       = 1'b1;
              cnt_load_value = GAP_LOAD;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_dec        = 1'b1;
            stretched_next = 1'b1;
          end
        end
      end
      GAP: begin
        dropped_next = bus.pulse_in;
        if (cnt_zero) begin
          state_next = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      stretched_reg <= 1'b0;
      dropped_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      stretched_reg <= stretched_next;
      dropped_reg   <= dropped_next;
    end
  end

  assign bus.stretched = stretched_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.dropped   = dropped_reg;

endmodule
